prio_enc_rr: RTL and testbench
==============================

Name: prio_enc_rr

Overview:
- Parametrised, registered priority encoder. Generalises the fixed 8-to-3 LSB-first encoder to any width W.
- Adds three things: a selectable priority mode (LSB-first, MSB-first, round-robin), a valid/ready handshake on both sides, and a "no request" flag.
- Used as the request-select stage in front of shared resources, such as display mux and bus masters in lab top-levels.

Parameters:
- W, 8, number of request lines (W >= 2).
- PW, $clog2(W), index width. Derived; do not override.
- MODE, 0, priority mode: 0 = fixed LSB-first, 1 = fixed MSB-first, 2 = round-robin. Any other value behaves as 0.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  req is valid this cycle.
- in_ready  output  1  block can accept req this cycle.
- req  input  W  request vector.
- out_valid  output  1  result register holds a result.
- out_ready  input  1  downstream accepts the result.
- out_pos  output  PW  index of the granted request.
- out_onehot  output  W  one-hot grant vector (1 << out_pos), or all-zero.
- out_none  output  1  1 when the accepted req was all-zero.

Behaviour:
- Reset (async on rst_n low): out_valid=0, out_pos=0, out_onehot=0, out_none=0, rr_ptr=0. Reset mid-transfer drops the held result with no further output.
- Handshake:
  - Input accept: acc_in = in_valid & in_ready.
  - Output transfer: acc_out = out_valid & out_ready.
  - in_ready = ~out_valid | out_ready (single result register; full-throughput pass-through).
  - in_ready is combinational from out_valid and out_ready only; never from in_valid.
- Latency: result registered 1 cycle after acc_in. Back-to-back acceptance every cycle while out_ready=1.
- out_valid update:
  - set on acc_in;
  - cleared on acc_out without acc_in;
  - held at 1 on simultaneous acc_in & acc_out, with the new result replacing the old.
- Result fields are stable while out_valid=1 & out_ready=0, and req is ignored then (in_ready=0).
- Encoding on acc_in, req != 0:
  - MODE 0: out_pos = lowest set index.
  - MODE 1: out_pos = highest set index.
  - MODE 2: out_pos = first set index scanning upward from rr_ptr, wrapping W-1 -> 0.
  - In all modes: out_onehot = 1 << out_pos, out_none = 0.
- Encoding on acc_in, req == 0: out_pos=0, out_onehot=0, out_none=1, out_valid=1 (an empty result is still a result).
- Round-robin pointer (MODE 2 only):
  - On acc_in with req != 0: rr_ptr <= (grant+1) mod W. The wrap is explicit so it also holds when W is not a power of two.
  - On acc_in with req == 0: rr_ptr unchanged.
  - No change when acc_in is false.
  - In MODE 0/1, rr_ptr stays 0 and is unused.
  - rr_ptr is PW bits wide; it must never hold a value >= W.
- Fairness: in MODE 2, under constant all-ones req, successive grants cycle 0,1,...,W-1,0 with no repeats within W grants.
- Non-power-of-two W (e.g. W=5): indices >= W never appear on out_pos.
- X on req while in_valid=0 must not propagate to the outputs or to rr_ptr.

Test Plan:
- Reset and fixed LSB-first order:
  - Reset with in_valid held 1 -> out_valid=0, out_onehot=0, in_ready=1.
  - Release reset; MODE 0, W=8, req=8'b0101_1000 accepted -> next cycle out_pos=3, out_onehot=8'h08, out_none=0.
- Fixed MSB-first: MODE 1, req=8'b0101_1000 -> out_pos=6. req=8'h00 -> out_pos=0, out_onehot=0, out_none=1, out_valid=1.
- Round-robin order, MODE 2, W=8:
  - req=8'hFF on 10 consecutive accepts with out_ready=1 -> out_pos sequence 0,1,2,3,4,5,6,7,0,1.
  - Then req=8'b0000_0101 -> out_pos=2 (rr_ptr=2), then 0 (rr_ptr=3 wraps past 7).
- Backpressure:
  - Hold out_ready=0 after one accept -> in_ready=0, and out_pos/out_onehot stay frozen for 5 cycles despite req changing.
  - Raise out_ready together with a new in_valid -> same-cycle replace; out_valid stays 1 and the new result appears next cycle.
- Non-power-of-two round-robin: MODE 2, W=5, req=5'b10001 -> grants 0,4,0,4; rr_ptr never exceeds 4. req=5'b10000 from rr_ptr=0 -> out_pos=4.
- Async reset mid-stream: assert rst_n=0 asynchronously while out_valid=1 & out_ready=0 -> out_valid drops immediately and rr_ptr=0. The first grant after release with req=8'hFF is 0.

Source files
------------

// File: rtl/prio_enc_rr.sv
// Registered W-input priority encoder with LSB/MSB/round-robin selection,
// valid/ready handshake on both sides and an empty-request flag.
module prio_enc_rr #(
  parameter  int W    = 8,
  parameter  int MODE = 0,
  localparam int PW   = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  req,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_pos,
  output logic [W-1:0]  out_onehot,
  output logic          out_none
);

  logic          out_valid_q, out_valid_d;
  logic [PW-1:0] out_pos_q, out_pos_d;
  logic [W-1:0]  out_onehot_q, out_onehot_d;
  logic          out_none_q, out_none_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;

  logic          acc_in;
  logic          req_any;
  logic [PW-1:0] lsb_pos, msb_pos, rr_pos, grant;

  assign in_ready = ~out_valid_q | out_ready;
  assign acc_in   = in_valid & in_ready;
  assign req_any  = |req;

  always_comb begin
    lsb_pos = '0;
    msb_pos = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (req[i]) lsb_pos = PW'(i);
    end
    for (int i = 0; i < W; i++) begin
      if (req[i]) msb_pos = PW'(i);
    end
  end

  // Scan downward from rr_ptr+W-1 so the last hit is the first set bit at or
  // above rr_ptr; rr_ptr < W keeps the wrapped index below 2W.
  always_comb begin
    int idx;
    rr_pos = '0;
    for (int k = W - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= W) idx = idx - W;
      if (req[PW'(idx)]) rr_pos = PW'(idx);
    end
  end

  always_comb begin
    if (MODE == 1)      grant = msb_pos;
    else if (MODE == 2) grant = rr_pos;
    else                grant = lsb_pos;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_pos_d    = out_pos_q;
    out_onehot_d = out_onehot_q;
    out_none_d   = out_none_q;
    rr_ptr_d     = rr_ptr_q;
    if (acc_in) begin
      out_valid_d = 1'b1;
      out_none_d  = ~req_any;
      if (req_any) begin
        out_pos_d    = grant;
        out_onehot_d = W'(1) << grant;
        if (MODE == 2) begin
          rr_ptr_d = (int'(grant) == W - 1) ? '0 : grant + PW'(1);
        end
      end else begin
        out_pos_d    = '0;
        out_onehot_d = '0;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_pos_q    <= '0;
      out_onehot_q <= '0;
      out_none_q   <= 1'b0;
      rr_ptr_q     <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_pos_q    <= out_pos_d;
      out_onehot_q <= out_onehot_d;
      out_none_q   <= out_none_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_pos    = out_pos_q;
  assign out_onehot = out_onehot_q;
  assign out_none   = out_none_q;

endmodule

// File: tb/tb_prio_enc_rr.sv
// Scoreboard bench for prio_enc_rr: four instances (LSB, MSB, RR W=8, RR W=5)
// driven in lockstep, checked against a behavioural grant model.
module tb_prio_enc_rr;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] req;

  logic [N-1:0] in_ready_v, out_valid_v, out_none_v;
  logic [2:0]   pos0, pos1, pos2, pos3;
  logic [7:0]   oh0, oh1, oh2;
  logic [4:0]   oh3;

  prio_enc_rr #(.W(8), .MODE(0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[0]),
    .req(req), .out_valid(out_valid_v[0]), .out_ready(out_ready),
    .out_pos(pos0), .out_onehot(oh0), .out_none(out_none_v[0]));

  prio_enc_rr #(.W(8), .MODE(1)) u_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[1]),
    .req(req), .out_valid(out_valid_v[1]), .out_ready(out_ready),
    .out_pos(pos1), .out_onehot(oh1), .out_none(out_none_v[1]));

  prio_enc_rr #(.W(8), .MODE(2)) u_rr8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[2]),
    .req(req), .out_valid(out_valid_v[2]), .out_ready(out_ready),
    .out_pos(pos2), .out_onehot(oh2), .out_none(out_none_v[2]));

  prio_enc_rr #(.W(5), .MODE(2)) u_rr5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[3]),
    .req(req[4:0]), .out_valid(out_valid_v[3]), .out_ready(out_ready),
    .out_pos(pos3), .out_onehot(oh3), .out_none(out_none_v[3]));

  always #5 clk = ~clk;

  logic [2:0] apos [N];
  logic [7:0] aoh  [N];
  assign apos[0] = pos0;
  assign apos[1] = pos1;
  assign apos[2] = pos2;
  assign apos[3] = pos3;
  assign aoh[0]  = oh0;
  assign aoh[1]  = oh1;
  assign aoh[2]  = oh2;
  assign aoh[3]  = {3'b000, oh3};

  typedef struct packed {
    logic [N-1:0][7:0] oh;
    logic [N-1:0][2:0] pos;
    logic [N-1:0]      none;
  } exp_t;

  exp_t sb[$];
  int   wid  [N] = '{8, 8, 8, 5};
  int   mode [N] = '{0, 1, 2, 2};
  int   ptr  [N];
  bit   mv;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference grant: first set request met when walking the lines in the
  // mode's priority order; -1 when nothing is requested.
  function automatic int grant_of(input logic [7:0] r, input int m, input int w, input int p);
    if (m == 1) begin
      for (int i = w - 1; i >= 0; i--) if (r[i]) return i;
    end else if (m == 2) begin
      for (int k = 0; k < w; k++) if (r[(p + k) % w]) return (p + k) % w;
    end else begin
      for (int i = 0; i < w; i++) if (r[i]) return i;
    end
    return -1;
  endfunction

  // One clock of stimulus: drive, let the edge happen, record any accept.
  task automatic cycle(input logic v, input logic [7:0] r, input logic ordy);
    bit   acc;
    int   g;
    exp_t e;
    in_valid  = v;
    req       = r;
    out_ready = ordy;
    @(posedge clk);
    acc = v && (!mv || ordy);
    if (acc) begin
      e = '0;
      for (int i = 0; i < N; i++) begin
        g = grant_of(r, mode[i], wid[i], ptr[i]);
        if (g < 0) begin
          e.none[i] = 1'b1;
        end else begin
          e.pos[i] = 3'(g);
          e.oh[i]  = 8'(1 << g);
          if (mode[i] == 2) ptr[i] = (g + 1) % wid[i];
        end
      end
      sb.push_back(e);
    end
    mv = acc || (mv && !ordy);
    #1;
  endtask

  task automatic clear_model();
    sb.delete();
    mv = 1'b0;
    for (int i = 0; i < N; i++) ptr[i] = 0;
  endtask

  task automatic do_reset();
    repeat (2) cycle(1'b0, 8'hxx, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares the presented result with the scoreboard head every
  // cycle, and retires the head on the edge that transfers it.
  always @(negedge clk) begin
    bit   hv;
    exp_t e;
    if (rst_n) begin
      hv = (sb.size() != 0);
      for (int i = 0; i < N; i++) begin
        check("in_ready", 32'(in_ready_v[i]), 32'(!hv || out_ready));
        check("out_valid", 32'(out_valid_v[i]), 32'(hv));
      end
      if (hv) begin
        e = sb[0];
        for (int i = 0; i < N; i++) begin
          check("out_pos", 32'(apos[i]), 32'(e.pos[i]));
          check("out_onehot", 32'(aoh[i]), 32'(e.oh[i]));
          check("out_none", 32'(out_none_v[i]), 32'(e.none[i]));
        end
        if (out_ready) begin
          @(posedge clk);
          if (sb.size() != 0) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    clear_model();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    req       = 8'hFF;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid_v), 32'h0);
    check("rst_onehot", 32'(oh0 | oh1 | oh2 | {3'b000, oh3}), 32'h0);
    check("rst_in_ready", 32'(in_ready_v), 32'hF);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;

    cycle(1'b1, 8'b0101_1000, 1'b1);
    check("lsb_pos", 32'(pos0), 32'd3);
    check("lsb_onehot", 32'(oh0), 32'h08);
    check("msb_pos", 32'(pos1), 32'd6);
    cycle(1'b1, 8'h00, 1'b1);
    check("empty_pos", 32'(pos1), 32'd0);
    check("empty_onehot", 32'(oh1), 32'h0);
    check("empty_none", 32'(out_none_v[1]), 32'd1);
    check("empty_valid", 32'(out_valid_v[1]), 32'd1);

    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 8'hFF, 1'b1);
      check("rr_seq", 32'(pos2), 32'(i % 8));
    end
    cycle(1'b1, 8'b0000_0101, 1'b1);
    check("rr_skip", 32'(pos2), 32'd2);
    cycle(1'b1, 8'b0000_0101, 1'b1);
    check("rr_wrap", 32'(pos2), 32'd0);

    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 8'b0001_0001, 1'b1);
      check("rr5_alt", 32'(pos3), (i % 2 == 0) ? 32'd0 : 32'd4);
    end
    do_reset();
    cycle(1'b1, 8'b0001_0000, 1'b1);
    check("rr5_top", 32'(pos3), 32'd4);

    cycle(1'b1, 8'h3C, 1'b1);
    for (int i = 0; i < 5; i++) begin
      r = 8'($urandom);
      cycle(1'b1, r, 1'b0);
      check("bp_in_ready", 32'(in_ready_v), 32'h0);
      check("bp_hold_pos", 32'(pos0), 32'd2);
    end
    cycle(1'b1, 8'hC0, 1'b1);
    check("replace_valid", 32'(out_valid_v), 32'hF);
    check("replace_pos", 32'(pos0), 32'd6);
    cycle(1'b0, 8'hxx, 1'b1);

    for (int i = 0; i < 400; i++) begin
      logic v, o;
      v = ($urandom % 4) != 0;
      o = ($urandom % 3) != 0;
      r = (($urandom % 6) == 0) ? 8'h00 : 8'($urandom);
      if (!v) r = 8'hxx;
      cycle(v, r, o);
    end

    cycle(1'b1, 8'hA5, 1'b1);
    cycle(1'b0, 8'hxx, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid_v), 32'h0);
    check("async_rst_onehot", 32'(oh2), 32'h0);
    in_valid = 1'b0;
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b1, 8'hFF, 1'b1);
    check("post_rst_rr8", 32'(pos2), 32'd0);
    check("post_rst_rr5", 32'(pos3), 32'd0);

    repeat (3) cycle(1'b0, 8'hxx, 1'b1);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
